// File: rtl/weight_fifo_pkg.sv
// Shared items for the weight FIFO bank controllers.
package weight_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wfifo_rd_state_e;

  // Counter must reach DEPTH+WIDTH-2 and compare against i+DEPTH without wrapping.
  function automatic int unsigned wfifo_cnt_width(input int unsigned depth,
                                                  input int unsigned width);
    return $clog2(depth + width);
  endfunction

endpackage

// File: rtl/weight_fifo_out_ctrl.sv
// Drains every column FIFO of the weight bank with one cycle of skew per column,
// producing the diagonal wavefront the systolic array expects.
module weight_fifo_out_ctrl
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic [FIFO_WIDTH-1:0] fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] rd_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = wfifo_cnt_width(FIFO_DEPTH, FIFO_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FIFO_DEPTH + FIFO_WIDTH - 2);

  wfifo_rd_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] rd_valid_q;
  logic                  drain_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= fifo_rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drain_act = (state_q == DRAIN) && !hold;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    rd_valid  = rd_valid_q;
  end

  // Column i reads while cnt lies in [i, i+DEPTH); column 0 has no lower bound.
  for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_col
    localparam logic [CNT_W-1:0] HI = CNT_W'(i + FIFO_DEPTH);
    if (i == 0) begin : g_first
      assign fifo_rd_en[i] = drain_act && (cnt_q < HI);
    end else begin : g_rest
      localparam logic [CNT_W-1:0] LO = CNT_W'(i);
      assign fifo_rd_en[i] = drain_act && (cnt_q >= LO) && (cnt_q < HI);
    end
  end

endmodule

// File: tb/tb_weight_fifo_out_ctrl.sv
// Scoreboard bench for weight_fifo_out_ctrl: main instance W=4/D=4 plus W=1/D=1 and W=16/D=16.
module tb_weight_fifo_out_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, hold = 1'b0;
  logic start1 = 1'b0, start16 = 1'b0, hold_e = 1'b0;

  logic [3:0]  en4, val4;
  logic        busy4, done4;
  logic [0:0]  en1, val1;
  logic        busy1, done1;
  logic [15:0] en16, val16;
  logic        busy16, done16;

  weight_fifo_out_ctrl #(.FIFO_WIDTH(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .fifo_rd_en(en4), .rd_valid(val4), .busy(busy4), .done(done4));

  weight_fifo_out_ctrl #(.FIFO_WIDTH(1), .FIFO_DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold_e),
    .fifo_rd_en(en1), .rd_valid(val1), .busy(busy1), .done(done1));

  weight_fifo_out_ctrl #(.FIFO_WIDTH(16), .FIFO_DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .hold(hold_e),
    .fifo_rd_en(en16), .rd_valid(val16), .busy(busy16), .done(done16));

  typedef struct {
    int unsigned dut;
    logic [15:0] en;
    logic [15:0] val;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]  p_en4  = '0;
  logic        p_rst  = 1'b1;
  logic        p_en1  = 1'b0;
  logic [15:0] p_en16 = '0;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every queued expectation belongs to the cycle being sampled.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] a_en, a_val;
    logic a_b, a_d;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin a_en = {12'h0, en4}; a_val = {12'h0, val4}; a_b = busy4; a_d = done4; end
        1: begin a_en = {15'h0, en1}; a_val = {15'h0, val1}; a_b = busy1; a_d = done1; end
        default: begin a_en = en16; a_val = val16; a_b = busy16; a_d = done16; end
      endcase
      chk({e.tag, ".rd_en"},    a_en,         e.en);
      chk({e.tag, ".rd_valid"}, a_val,        e.val);
      chk({e.tag, ".busy"},     {15'h0, a_b}, {15'h0, e.busy});
      chk({e.tag, ".done"},     {15'h0, a_d}, {15'h0, e.done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the W=4 instance: inputs driven for this cycle and hand-computed outputs.
  task automatic cyc(input logic s, input logic h, input logic r,
                     input logic [3:0] en, input logic b, input logic d, input string tag);
    tick();
    start = s; hold = h; rst = r;
    sb.push_back('{0, {12'h0, en}, p_rst ? 16'h0 : {12'h0, p_en4}, b, d, tag});
    p_en4 = en;
    p_rst = r;
  endtask

  task automatic edge_params();
    logic        e1;
    logic [15:0] e16;
    tick();
    start1 = 1'b1; start16 = 1'b1;
    sb.push_back('{1, 16'h0, 16'h0, 1'b0, 1'b0, "w1.c0"});
    sb.push_back('{2, 16'h0, 16'h0, 1'b0, 1'b0, "w16.c0"});
    for (int c = 1; c <= 34; c++) begin
      tick();
      start1 = 1'b0; start16 = 1'b0;
      e1 = (c == 1);
      for (int i = 0; i < 16; i++) e16[i] = (c >= 1 + i) && (c <= 16 + i);
      sb.push_back('{1, {15'h0, e1}, {15'h0, p_en1}, (c >= 1 && c <= 2), (c == 2),
                     $sformatf("w1.c%0d", c)});
      sb.push_back('{2, e16, p_en16, (c >= 1 && c <= 32), (c == 32),
                     $sformatf("w16.c%0d", c)});
      p_en1 = e1;
      p_en16 = e16;
    end
  endtask

  task automatic rand_hold();
    int unsigned n = 0, bad = 0;
    int unsigned cnt[4], first[4];
    bit got_done = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; first[i] = 0; end
    tick();
    start = 1'b1; hold = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (en4[i]) begin
          if (cnt[i] == 0) first[i] = n;
          cnt[i]++;
        end
      if (en4 != 4'h0 && (!busy4 || done4)) bad++;
      if (done4) got_done = 1'b1;
      if (busy4 && !done4 && !hold) n++;
      tick();
      start = 1'b0;
      hold = 1'($urandom_range(0, 1));
    end
    hold = 1'b0;
    chk("rand.done_seen", {15'h0, got_done}, 16'h1);
    chk("rand.en_outside_drain", 16'(bad), 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand.pulses%0d", i), 16'(cnt[i]), 16'h4);
      chk($sformatf("rand.skew%0d", i), 16'(first[i]), 16'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    cyc(0, 0, 1, 4'b0000, 0, 0, "reset");

    // Basic drain
    cyc(1, 0, 0, 4'b0000, 0, 0, "A.c0");
    cyc(0, 0, 0, 4'b0001, 1, 0, "A.c1");
    cyc(0, 0, 0, 4'b0011, 1, 0, "A.c2");
    cyc(0, 0, 0, 4'b0111, 1, 0, "A.c3");
    cyc(0, 0, 0, 4'b1111, 1, 0, "A.c4");
    cyc(0, 0, 0, 4'b1110, 1, 0, "A.c5");
    cyc(0, 0, 0, 4'b1100, 1, 0, "A.c6");
    cyc(0, 0, 0, 4'b1000, 1, 0, "A.c7");
    cyc(0, 0, 0, 4'b0000, 1, 1, "A.c8");
    cyc(0, 0, 0, 4'b0000, 0, 0, "A.c9");

    // Stall in cycles 3-4, then hold in DONE and IDLE has no effect
    cyc(1, 0, 0, 4'b0000, 0, 0, "B.c0");
    cyc(0, 0, 0, 4'b0001, 1, 0, "B.c1");
    cyc(0, 0, 0, 4'b0011, 1, 0, "B.c2");
    cyc(0, 1, 0, 4'b0000, 1, 0, "B.c3");
    cyc(0, 1, 0, 4'b0000, 1, 0, "B.c4");
    cyc(0, 0, 0, 4'b0111, 1, 0, "B.c5");
    cyc(0, 0, 0, 4'b1111, 1, 0, "B.c6");
    cyc(0, 0, 0, 4'b1110, 1, 0, "B.c7");
    cyc(0, 0, 0, 4'b1100, 1, 0, "B.c8");
    cyc(0, 0, 0, 4'b1000, 1, 0, "B.c9");
    cyc(0, 1, 0, 4'b0000, 1, 1, "B.c10");
    cyc(0, 1, 0, 4'b0000, 0, 0, "B.c11");

    // Start while busy (incl. DONE cycle) ignored; start in cycle 9 accepted
    cyc(1, 0, 0, 4'b0000, 0, 0, "C.c0");
    cyc(0, 0, 0, 4'b0001, 1, 0, "C.c1");
    cyc(1, 0, 0, 4'b0011, 1, 0, "C.c2");
    cyc(0, 0, 0, 4'b0111, 1, 0, "C.c3");
    cyc(0, 0, 0, 4'b1111, 1, 0, "C.c4");
    cyc(0, 0, 0, 4'b1110, 1, 0, "C.c5");
    cyc(0, 0, 0, 4'b1100, 1, 0, "C.c6");
    cyc(0, 0, 0, 4'b1000, 1, 0, "C.c7");
    cyc(1, 0, 0, 4'b0000, 1, 1, "C.c8");
    cyc(1, 0, 0, 4'b0000, 0, 0, "C.c9");
    cyc(0, 0, 0, 4'b0001, 1, 0, "C.c10");
    cyc(0, 0, 0, 4'b0011, 1, 0, "C.c11");
    cyc(0, 0, 0, 4'b0111, 1, 0, "C.c12");
    cyc(0, 0, 0, 4'b1111, 1, 0, "C.c13");
    cyc(0, 0, 0, 4'b1110, 1, 0, "C.c14");
    cyc(0, 0, 0, 4'b1100, 1, 0, "C.c15");
    cyc(0, 0, 0, 4'b1000, 1, 0, "C.c16");
    cyc(0, 0, 0, 4'b0000, 1, 1, "C.c17");
    cyc(0, 0, 0, 4'b0000, 0, 0, "C.c18");

    // Reset mid-drain, then a clean restart
    cyc(1, 0, 0, 4'b0000, 0, 0, "D.c0");
    cyc(0, 0, 0, 4'b0001, 1, 0, "D.c1");
    cyc(0, 0, 0, 4'b0011, 1, 0, "D.c2");
    cyc(0, 0, 0, 4'b0111, 1, 0, "D.c3");
    cyc(0, 0, 0, 4'b1111, 1, 0, "D.c4");
    cyc(0, 0, 1, 4'b1110, 1, 0, "D.c5");
    cyc(1, 0, 0, 4'b0000, 0, 0, "D.c6");
    cyc(0, 0, 0, 4'b0001, 1, 0, "D.c7");
    cyc(0, 0, 0, 4'b0011, 1, 0, "D.c8");
    cyc(0, 0, 0, 4'b0111, 1, 0, "D.c9");
    cyc(0, 0, 0, 4'b1111, 1, 0, "D.c10");
    cyc(0, 0, 0, 4'b1110, 1, 0, "D.c11");
    cyc(0, 0, 0, 4'b1100, 1, 0, "D.c12");
    cyc(0, 0, 0, 4'b1000, 1, 0, "D.c13");
    cyc(0, 0, 0, 4'b0000, 1, 1, "D.c14");
    cyc(0, 0, 0, 4'b0000, 0, 0, "D.c15");

    edge_params();
    rand_hold();

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
